// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter that time-shares one i2c_master command port among N_REQ clients,
// with NACK retries, a wait timeout and a fixed idle gap after every bus attempt.
module i2c_bus_arbiter #(
  parameter int N_REQ          = 4,
  parameter int MAX_RETRY      = 2,
  parameter int GAP_CYCLES     = 50,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   req_addr_rw,
  input  logic [8*N_REQ-1:0]   req_wdata,
  output logic [N_REQ-1:0]     done,
  output logic [7:0]           resp_rdata,
  output logic [1:0]           resp_err,
  output logic                 busy,
  output logic                 mst_start,
  output logic [7:0]           mst_addr_rw,
  output logic [7:0]           mst_tx_data,
  input  logic [7:0]           mst_rx_data,
  input  logic                 mst_done,
  input  logic                 mst_error
);

  localparam int IW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] G_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [2:0]    R_MAX  = 3'(MAX_RETRY);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_RESP   = 3'd3;
  localparam logic [2:0] S_GAP    = 3'd4;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_NACK = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;

  logic [2:0]    state, state_nx;
  logic [IW-1:0] ptr, cur_idx, pick;
  logic [2:0]    retry_cnt;
  logic          retry_pend;
  logic [TW-1:0] tcnt;
  logic [GW-1:0] gcnt;
  logic          mst_done_r, done_q, err_r;
  logic [7:0]    rx_r;
  logic          done_rise;
  logic [7:0]    slot_addr [N_REQ];
  logic [7:0]    slot_data [N_REQ];

  // Lowest set request above p, otherwise wrap to the lowest set request overall.
  function automatic logic [IW-1:0] rr_pick(input logic [N_REQ-1:0] r, input logic [IW-1:0] p);
    logic [IW-1:0] hi, lo;
    logic          hi_ok;
    hi    = '0;
    lo    = '0;
    hi_ok = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (r[i]) begin
        lo = IW'(i);
        if (IW'(i) > p) begin
          hi    = IW'(i);
          hi_ok = 1'b1;
        end
      end
    end
    return hi_ok ? hi : lo;
  endfunction

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      slot_addr[i] = req_addr_rw[8*i +: 8];
      slot_data[i] = req_wdata[8*i +: 8];
    end
  end

  assign pick      = rr_pick(req, ptr);
  assign done_rise = mst_done_r & ~done_q;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (|req) state_nx = S_LAUNCH;
      S_LAUNCH: state_nx = S_WAIT;
      S_WAIT: begin
        if (done_rise)
          state_nx = (err_r && (retry_cnt < R_MAX)) ? S_GAP : S_RESP;
        else if (tcnt == T_LAST)
          state_nx = S_RESP;
      end
      S_RESP:   state_nx = S_GAP;
      S_GAP:    if (gcnt == G_LAST) state_nx = retry_pend ? S_LAUNCH : S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      ptr         <= IW'(N_REQ - 1);
      cur_idx     <= '0;
      retry_cnt   <= '0;
      retry_pend  <= 1'b0;
      tcnt        <= '0;
      gcnt        <= '0;
      mst_done_r  <= 1'b1;
      done_q      <= 1'b1;
      err_r       <= 1'b0;
      rx_r        <= '0;
      done        <= '0;
      resp_rdata  <= '0;
      resp_err    <= ERR_OK;
      busy        <= 1'b0;
      mst_start   <= 1'b0;
      mst_addr_rw <= '0;
      mst_tx_data <= '0;
    end else begin
      state      <= state_nx;
      // Input sampling stage: the master's done level and its qualifiers are registered together.
      mst_done_r <= mst_done;
      done_q     <= mst_done_r;
      err_r      <= mst_error;
      rx_r       <= mst_rx_data;
      mst_start  <= (state_nx == S_LAUNCH);
      busy       <= (state_nx != S_IDLE);
      done       <= '0;

      case (state)
        S_IDLE: begin
          if (|req) begin
            cur_idx     <= pick;
            mst_addr_rw <= slot_addr[pick];
            mst_tx_data <= slot_data[pick];
            retry_cnt   <= '0;
          end
        end
        S_LAUNCH: tcnt <= '0;
        S_WAIT: begin
          tcnt <= tcnt + TW'(1);
          if (done_rise) begin
            if (!err_r) begin
              resp_err   <= ERR_OK;
              resp_rdata <= mst_addr_rw[0] ? rx_r : 8'h00;
            end else if (retry_cnt < R_MAX) begin
              retry_cnt  <= retry_cnt + 3'd1;
              retry_pend <= 1'b1;
            end else begin
              resp_err   <= ERR_NACK;
              resp_rdata <= 8'h00;
            end
          end else if (tcnt == T_LAST) begin
            resp_err   <= ERR_TMO;
            resp_rdata <= 8'h00;
          end
        end
        S_RESP: ptr <= cur_idx;
        S_GAP: begin
          if (gcnt == G_LAST) begin
            gcnt       <= '0;
            retry_pend <= 1'b0;
          end else begin
            gcnt <= gcnt + GW'(1);
          end
        end
        default: ;
      endcase

      // Completion pulse coincides with the RESP state.
      if (state == S_WAIT && state_nx == S_RESP)
        done[cur_idx] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Bench for i2c_bus_arbiter: behavioural i2c_master stub plus a round-robin/retry reference model.
module tb_i2c_bus_arbiter;
  localparam int N_REQ          = 4;
  localparam int MAX_RETRY      = 2;
  localparam int GAP_CYCLES     = 50;
  localparam int TIMEOUT_CYCLES = 100;
  localparam logic [6:0] NACK_ADDR = 7'h77;
  localparam logic [6:0] HANG_ADDR = 7'h3F;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [N_REQ-1:0]     req = '0;
  logic [8*N_REQ-1:0]   req_addr_rw = '0;
  logic [8*N_REQ-1:0]   req_wdata = '0;
  logic [N_REQ-1:0]     done;
  logic [7:0]           resp_rdata;
  logic [1:0]           resp_err;
  logic                 busy;
  logic                 mst_start;
  logic [7:0]           mst_addr_rw;
  logic [7:0]           mst_tx_data;
  logic [7:0]           mst_rx_data = '0;
  logic                 mst_done = 1'b0;
  logic                 mst_error = 1'b0;

  i2c_bus_arbiter #(
    .N_REQ(N_REQ), .MAX_RETRY(MAX_RETRY),
    .GAP_CYCLES(GAP_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr_rw(req_addr_rw), .req_wdata(req_wdata),
    .done(done), .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy),
    .mst_start(mst_start), .mst_addr_rw(mst_addr_rw), .mst_tx_data(mst_tx_data),
    .mst_rx_data(mst_rx_data), .mst_done(mst_done), .mst_error(mst_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [7:0] addr_rw; logic [7:0] tx; } start_t;
  typedef struct { int cyc; logic [N_REQ-1:0] vec; logic [7:0] rdata; logic [1:0] err; } done_t;

  start_t     slog[$];
  done_t      dq[$];
  start_t     s_ent;
  done_t      d_ent;
  logic [7:0] mem [128];
  int         rise_cyc = 0;
  bit         pend = 0;
  int         lat = 0;
  int         hold = 0;
  logic [7:0] cur_ar = '0;

  int checks = 0;
  int errors = 0;

  // Reference state: last served requester and the per-slot request contents.
  int         last;
  int         prev_done;
  logic [7:0] m_ar [N_REQ];
  logic [7:0] m_wd [N_REQ];

  // Slave stub and output monitor, both sampling on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      pend = 0; hold = 0; mst_done = 1'b0; mst_error = 1'b0;
    end else begin
      if (|done) begin
        d_ent.cyc = cyc; d_ent.vec = done; d_ent.rdata = resp_rdata; d_ent.err = resp_err;
        dq.push_back(d_ent);
      end
      if (hold > 0) begin
        hold--;
        if (hold == 0) mst_done = 1'b0;
      end
      if (mst_start) begin
        s_ent.cyc = cyc; s_ent.addr_rw = mst_addr_rw; s_ent.tx = mst_tx_data;
        slog.push_back(s_ent);
        if (mst_addr_rw[7:1] != HANG_ADDR) begin
          pend = 1; lat = $urandom_range(3, 12); cur_ar = mst_addr_rw;
        end
      end else if (pend) begin
        if (lat > 0) lat--;
        else begin
          pend        = 0;
          mst_error   = (cur_ar[7:1] == NACK_ADDR);
          mst_rx_data = (!mst_error && cur_ar[0]) ? mem[cur_ar[7:1]] : 8'($urandom);
          mst_done    = 1'b1;
          hold        = 2;
          rise_cyc    = cyc;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_ge(input string tag, input int obs, input int min);
    checks++;
    assert (obs >= min) else begin
      errors++;
      $error("FAIL %s: observed %0d expected >= %0d", tag, obs, min);
    end
  endtask

  task automatic check_idle_outputs(input string pfx);
    check({pfx, "_done"},      32'(done),        32'h0);
    check({pfx, "_rdata"},     32'(resp_rdata),  32'h0);
    check({pfx, "_err"},       32'(resp_err),    32'h0);
    check({pfx, "_busy"},      32'(busy),        32'h0);
    check({pfx, "_start"},     32'(mst_start),   32'h0);
    check({pfx, "_addr_rw"},   32'(mst_addr_rw), 32'h0);
    check({pfx, "_tx_data"},   32'(mst_tx_data), 32'h0);
  endtask

  function automatic int rr_next(input logic [N_REQ-1:0] mask, input int from);
    for (int k = 1; k <= N_REQ; k++)
      if (mask[(from + k) % N_REQ]) return (from + k) % N_REQ;
    return -1;
  endfunction

  task automatic set_slot(input int i, input logic [6:0] a, input logic rw, input logic [7:0] d);
    m_ar[i] = {a, rw};
    m_wd[i] = d;
    req_addr_rw[8*i +: 8] = {a, rw};
    req_wdata[8*i +: 8]   = d;
  endtask

  // Waits for the next completion and checks it against the model; idx = -1 if none arrived.
  task automatic serve(input logic [N_REQ-1:0] mask, output int idx);
    done_t      d;
    logic [6:0] a;
    logic [1:0] e_err;
    logic [7:0] e_rd;
    int         n_exp;
    idx   = rr_next(mask, last);
    a     = m_ar[idx][7:1];
    e_err = (a == HANG_ADDR) ? 2'b10 : (a == NACK_ADDR) ? 2'b01 : 2'b00;
    n_exp = (e_err == 2'b01) ? MAX_RETRY + 1 : 1;
    e_rd  = (e_err == 2'b00 && m_ar[idx][0]) ? mem[a] : 8'h00;
    for (int k = 0; k < 6000 && dq.size() == 0; k++) @(negedge clk);
    checks++;
    assert (dq.size() != 0) else begin
      errors++;
      $error("FAIL done_wait: observed no done expected done for requester %0d", idx);
    end
    if (dq.size() == 0) begin
      idx = -1;
      return;
    end
    d = dq.pop_front();
    check("done_vec",   32'(d.vec),   32'(1) << idx);
    check("resp_err",   32'(d.err),   32'(e_err));
    check("resp_rdata", 32'(d.rdata), 32'(e_rd));
    check("start_count", 32'(slog.size()), 32'(n_exp));
    for (int i = 0; i < slog.size(); i++) begin
      check("mst_addr_rw", 32'(slog[i].addr_rw), 32'(m_ar[idx]));
      check("mst_tx_data", 32'(slog[i].tx),      32'(m_wd[idx]));
      if (i > 0) check_ge("retry_gap", slog[i].cyc - slog[i-1].cyc, GAP_CYCLES);
    end
    if (prev_done >= 0 && slog.size() > 0)
      check_ge("b2b_gap", slog[0].cyc - prev_done, GAP_CYCLES + 2);
    if (e_err == 2'b10 && slog.size() > 0)
      check("timeout_lat", 32'(d.cyc - slog[slog.size()-1].cyc), 32'(TIMEOUT_CYCLES + 1));
    else
      check("done_lat", 32'(d.cyc - rise_cyc), 32'd2);
    slog.delete();
    prev_done = d.cyc;
    last      = idx;
  endtask

  initial begin
    int               idx;
    logic [N_REQ-1:0] mask;
    logic [6:0]       a;
    int               r;

    for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
    mem[7'h50] = 8'hCC;
    last      = N_REQ - 1;
    prev_done = -1;

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", 32'(busy), 32'h0);

    // Directed: write, read, NACK with retries, timeout.
    set_slot(0, 7'h50, 1'b0, 8'h55); req = 4'b0001; serve(4'b0001, idx); req = '0;
    set_slot(2, 7'h50, 1'b1, 8'h00); req = 4'b0100; serve(4'b0100, idx); req = '0;
    set_slot(1, NACK_ADDR, 1'b0, 8'hA1); req = 4'b0010; serve(4'b0010, idx); req = '0;
    set_slot(3, HANG_ADDR, 1'b1, 8'h00); req = 4'b1000; serve(4'b1000, idx); req = '0;
    repeat (GAP_CYCLES + 5) @(negedge clk);
    check("post_timeout_busy", 32'(busy), 32'h0);

    // Contention: all requests held high across eight grants.
    for (int i = 0; i < N_REQ; i++) set_slot(i, 7'h10 + 7'(i), 1'($urandom), 8'($urandom));
    req = 4'b1111;
    for (int n = 0; n < 8; n++) serve(4'b1111, idx);
    req = '0;

    // Randomized request sets, each requester dropping its request once served.
    for (int round = 0; round < 6; round++) begin
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < N_REQ; i++) begin
        r = $urandom_range(0, 9);
        a = (r == 0) ? NACK_ADDR : (r == 1) ? HANG_ADDR : 7'($urandom_range(1, 16'h6F));
        if (r > 1 && (a == NACK_ADDR || a == HANG_ADDR)) a = 7'h50;
        set_slot(i, a, 1'($urandom), 8'($urandom));
      end
      req = mask;
      while (mask != '0) begin
        serve(mask, idx);
        if (idx < 0) break;
        mask[idx] = 1'b0;
        req = mask;
      end
      req = '0;
    end

    // Reset while waiting on the master.
    set_slot(3, HANG_ADDR, 1'b0, 8'h12);
    req = 4'b1000;
    for (int k = 0; k < 2000 && slog.size() == 0; k++) @(negedge clk);
    check("midrst_launch", 32'(slog.size()), 32'd1);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    req = '0;
    @(negedge clk);
    check_idle_outputs("midrst");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    check("midrst_no_done", 32'(dq.size()), 32'd0);
    check("midrst_busy", 32'(busy), 32'h0);
    slog.delete();
    last      = N_REQ - 1;
    prev_done = -1;
    set_slot(0, 7'h50, 1'b1, 8'h00);
    set_slot(3, 7'h22, 1'b0, 8'h9A);
    mask = 4'b1001;
    req  = mask;
    serve(mask, idx);
    if (idx >= 0) begin
      mask[idx] = 1'b0;
      req = mask;
      serve(mask, idx);
    end
    req = '0;
    repeat (GAP_CYCLES + 5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
